// File: rtl/cv32e40p_cdec_tmr_ctrl_pkg.sv
// Types shared by the triplicated compressed-decoder controller and its voter.
// Holds the redundancy mode, the controller state and the per-replica result bundle.
// No ports; imported by cv32e40p_cdec_voter3 and cv32e40p_cdec_tmr_ctrl.
package cv32e40p_cdec_tmr_ctrl_pkg;

  typedef enum logic [1:0] {
    CDEC_MODE_TMR     = 2'd0,
    CDEC_MODE_DMR     = 2'd1,
    CDEC_MODE_SIMPLEX = 2'd2
  } cdec_mode_e;

  typedef enum logic {
    CDEC_ST_RUN   = 1'b0,
    CDEC_ST_RETRY = 1'b1
  } cdec_tmr_state_e;

  // One replica's decode result, compared and voted as a single 34-bit word.
  typedef struct packed {
    logic        illegal;
    logic        is_comp;
    logic [31:0] instr;
  } cdec_bundle_t;

  // Redundancy level follows the number of retired replicas, capped at simplex.
  function automatic cdec_mode_e cdec_mode_from_faulty(input logic [2:0] faulty);
    cdec_mode_e m;
    case (faulty)
      3'b000:                 m = CDEC_MODE_TMR;
      3'b001, 3'b010, 3'b100: m = CDEC_MODE_DMR;
      default:                m = CDEC_MODE_SIMPLEX;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cv32e40p_cdec_tmr_ctrl_voter3.sv
// Combinational voter over three decoder replica bundles, restricted to the healthy ones.
// Ports: bundle[2:0] replica results, healthy[2:0] replicas allowed to vote;
//        voted result, mismatch[2:0] healthy replicas disagreeing, agree = result trustworthy.
module cv32e40p_cdec_voter3
  import cv32e40p_cdec_tmr_ctrl_pkg::*;
(
  input  cdec_bundle_t [2:0] bundle,
  input  logic         [2:0] healthy,
  output cdec_bundle_t       voted,
  output logic         [2:0] mismatch,
  output logic               agree
);

  logic [33:0] w0, w1, w2, maj;
  logic [1:0]  lo, hi;

  always_comb begin
    w0       = bundle[0];
    w1       = bundle[1];
    w2       = bundle[2];
    maj      = (w0 & w1) | (w1 & w2) | (w0 & w2);
    voted    = bundle[0];
    mismatch = 3'b000;
    agree    = 1'b1;
    lo       = 2'd0;
    hi       = 2'd1;
    case (healthy)
      3'b111: begin
        voted    = cdec_bundle_t'(maj);
        mismatch = {w2 != maj, w1 != maj, w0 != maj};
        // A bitwise majority exists always, but it is only a real vote
        // when at least two replicas produced the identical bundle.
        agree    = (w0 == w1) || (w1 == w2) || (w0 == w2);
      end
      3'b011, 3'b101, 3'b110: begin
        lo           = healthy[0] ? 2'd0 : 2'd1;
        hi           = healthy[2] ? 2'd2 : 2'd1;
        voted        = bundle[lo];
        agree        = (bundle[lo] == bundle[hi]);
        mismatch[lo] = !agree;
        mismatch[hi] = !agree;
      end
      3'b010:  voted = bundle[1];
      3'b100:  voted = bundle[2];
      default: voted = bundle[0];
    endcase
  end

endmodule

// File: rtl/cv32e40p_cdec_tmr_ctrl.sv
// TMR controller for three compressed-decoder replicas: votes, retires faulty replicas, retries.
// Latency 1 cycle on agreement (plus retry cycles); full throughput when out_ready_i is held high.
// Backpressure: in_ready_o drops while the result is stalled or a retry is running.
// Ports: in_valid_i/in_ready_o/instr_i fetch side; dec_instr_o drives replicas, dec_*_i their results;
//        out_valid_o/out_ready_i/instr_o/is_compressed_o/illegal_instr_o/uncorrectable_o ID side;
//        faulty_o, mode_o health status; clear_i restores TMR.
// Optional: CDEC_TMR_STATS_EN adds corr_cnt_o/uncorr_cnt_o event counters.
module cv32e40p_cdec_tmr_ctrl
  import cv32e40p_cdec_tmr_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned FAULT_THRESH = 8,
  parameter int unsigned RETRY_MAX    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  output logic [31:0]     dec_instr_o,
  input  logic [2:0][31:0] dec_instr_i,
  input  logic [2:0]      dec_is_comp_i,
  input  logic [2:0]      dec_illegal_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     instr_o,
  output logic            is_compressed_o,
  output logic            illegal_instr_o,
  output logic            uncorrectable_o,
  output logic [2:0]      faulty_o,
  output logic [1:0]      mode_o,
  input  logic            clear_i
`ifdef CDEC_TMR_STATS_EN
  ,
  output logic [15:0]     corr_cnt_o,
  output logic [15:0]     uncorr_cnt_o
`endif
);

  localparam int unsigned      RW          = (RETRY_MAX > 1) ? $clog2(RETRY_MAX + 1) : 1;
  localparam logic [RW-1:0]    RETRY_MAX_W = RW'(RETRY_MAX);
  localparam logic [RW-1:0]    RETRY_LAST  = (RETRY_MAX > 0) ? RW'(RETRY_MAX - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] THRESH      = CNT_W'(FAULT_THRESH);

  cdec_tmr_state_e         state_q, state_d;
  logic [RW-1:0]           retry_cnt_q, retry_cnt_d;
  logic [31:0]             hold_q;
  logic [2:0]              word_healthy_q;
  logic [2:0]              faulty_q;
  logic [2:0][CNT_W-1:0]   cnt_q;
  logic [2:0]              cnt_upd, fault_set;

  cdec_bundle_t [2:0]      bundle;
  cdec_bundle_t            voted;
  logic [2:0]              mismatch;
  logic [2:0]              eval_healthy;
  logic                    agree, tmr_eval, out_free, accept;
  logic                    eval_en, load, load_uncorr, done;

  assign out_free    = !out_valid_o || out_ready_i;
  assign in_ready_o  = (state_q != CDEC_ST_RETRY) && out_free;
  assign accept      = in_valid_i && in_ready_o;
  assign dec_instr_o = (state_q == CDEC_ST_RETRY) ? hold_q : instr_i;
  assign faulty_o    = faulty_q;
  assign mode_o      = cdec_mode_from_faulty(faulty_q);

  // A retried word keeps the replica set it was accepted with, so a fault
  // flag raised mid-retry only affects the next accepted word.
  assign eval_healthy = (state_q == CDEC_ST_RETRY) ? word_healthy_q : ~faulty_q;
  assign tmr_eval     = &eval_healthy;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      bundle[k] = {dec_illegal_i[k], dec_is_comp_i[k], dec_instr_i[k]};
    end
  end

  cv32e40p_cdec_voter3 u_voter (
    .bundle   (bundle),
    .healthy  (eval_healthy),
    .voted    (voted),
    .mismatch (mismatch),
    .agree    (agree)
  );

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    eval_en     = 1'b0;
    load        = 1'b0;
    load_uncorr = 1'b0;
    done        = 1'b0;
    case (state_q)
      CDEC_ST_RUN: begin
        if (accept) begin
          eval_en = 1'b1;
          if (agree) begin
            load = 1'b1;
          end else begin
            state_d     = CDEC_ST_RETRY;
            retry_cnt_d = '0;
          end
        end
      end
      CDEC_ST_RETRY: begin
        done = agree || (retry_cnt_q >= RETRY_LAST);
        // Evaluations repeated only because the output is stalled must not
        // be counted again against the replicas.
        eval_en = (retry_cnt_q < RETRY_MAX_W) && (!done || out_free);
        if (done) begin
          if (out_free) begin
            load        = 1'b1;
            load_uncorr = !agree;
            state_d     = CDEC_ST_RUN;
            retry_cnt_d = '0;
          end else if (!agree) begin
            retry_cnt_d = RETRY_MAX_W;
          end
        end else begin
          retry_cnt_d = retry_cnt_q + RW'(1);
        end
      end
      default: state_d = CDEC_ST_RUN;
    endcase
  end

  // Mismatch counters only run under full TMR; DMR cannot tell which side is wrong.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      cnt_upd[k]   = eval_en && tmr_eval && mismatch[k] && (cnt_q[k] != CNT_MAX);
      fault_set[k] = cnt_upd[k] && ((cnt_q[k] + CNT_W'(1)) >= THRESH);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= CDEC_ST_RUN;
      retry_cnt_q    <= '0;
      hold_q         <= '0;
      word_healthy_q <= '0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
      if (accept) begin
        hold_q         <= instr_i;
        word_healthy_q <= ~faulty_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q    <= '0;
      faulty_q <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (cnt_upd[k]) begin
          cnt_q[k] <= cnt_q[k] + CNT_W'(1);
        end
      end
      faulty_q <= faulty_q | fault_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o     <= 1'b0;
      instr_o         <= '0;
      is_compressed_o <= 1'b0;
      illegal_instr_o <= 1'b0;
      uncorrectable_o <= 1'b0;
    end else if (load) begin
      out_valid_o     <= 1'b1;
      instr_o         <= voted.instr;
      is_compressed_o <= voted.is_comp;
      illegal_instr_o <= voted.illegal | load_uncorr;
      uncorrectable_o <= load_uncorr;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

`ifdef CDEC_TMR_STATS_EN
  // A word that went through retry had a disagreement even if the final
  // evaluation agreed, so it counts as corrected.
  logic corr_evt, uncorr_evt;
  assign corr_evt   = load && !load_uncorr && ((|mismatch) || (state_q == CDEC_ST_RETRY));
  assign uncorr_evt = load && load_uncorr;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      corr_cnt_o   <= '0;
      uncorr_cnt_o <= '0;
    end else begin
      if (corr_evt && (corr_cnt_o != 16'hFFFF)) begin
        corr_cnt_o <= corr_cnt_o + 16'd1;
      end
      if (uncorr_evt && (uncorr_cnt_o != 16'hFFFF)) begin
        uncorr_cnt_o <= uncorr_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cv32e40p_cdec_tmr_ctrl.sv
// Directed self-checking bench for cv32e40p_cdec_tmr_ctrl; the bench plays the three replicas.
// Inputs change 1 time unit after the rising edge; outputs are compared there too.
module tb_cv32e40p_cdec_tmr_ctrl;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr_in;
  logic [31:0]     dec_instr_out;
  logic [2:0][31:0] dec_instr;
  logic [2:0]      dec_comp;
  logic [2:0]      dec_ill;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     instr_out;
  logic            is_comp;
  logic            illegal;
  logic            uncorr;
  logic [2:0]      faulty;
  logic [1:0]      mode;
  logic            clear;
`ifdef CDEC_TMR_STATS_EN
  logic [15:0]     corr_cnt;
  logic [15:0]     uncorr_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  cv32e40p_cdec_tmr_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .instr_i         (instr_in),
    .dec_instr_o     (dec_instr_out),
    .dec_instr_i     (dec_instr),
    .dec_is_comp_i   (dec_comp),
    .dec_illegal_i   (dec_ill),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .instr_o         (instr_out),
    .is_compressed_o (is_comp),
    .illegal_instr_o (illegal),
    .uncorrectable_o (uncorr),
    .faulty_o        (faulty),
    .mode_o          (mode),
    .clear_i         (clear)
`ifdef CDEC_TMR_STATS_EN
    ,
    .corr_cnt_o      (corr_cnt),
    .uncorr_cnt_o    (uncorr_cnt)
`endif
  );

  task automatic set_reps(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic comp, input logic ill);
    dec_instr[0] = a;
    dec_instr[1] = b;
    dec_instr[2] = c;
    dec_comp     = {3{comp}};
    dec_ill      = {3{ill}};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0; instr_in = '0;
    set_reps(32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (instr_out !== 32'h0) $display("FAIL rst_instr: got %h want 0", instr_out); else pass_cnt++;
    total_cnt++; if ({illegal, is_comp, uncorr} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {illegal, is_comp, uncorr}); else pass_cnt++;
    total_cnt++; if (faulty !== 3'b000) $display("FAIL rst_faulty: got %b want 000", faulty); else pass_cnt++;
    total_cnt++; if (mode !== 2'd0) $display("FAIL rst_mode: got %0d want 0", mode); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_tmr_correct();
    @(posedge clk); #1;
    set_reps(32'h00108093, 32'h00108093, 32'h00108093, 1'b1, 1'b0);
    instr_in = 32'h0000_0085; in_valid = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL tmr_ready: got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (dec_instr_out !== 32'h85) $display("FAIL tmr_dec_instr: got %h want 00000085", dec_instr_out); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL tmr_valid: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (instr_out !== 32'h00108093) $display("FAIL tmr_instr: got %h want 00108093", instr_out); else pass_cnt++;
    total_cnt++; if ({illegal, is_comp, uncorr} !== 3'b010) $display("FAIL tmr_flags: got %b want 010", {illegal, is_comp, uncorr}); else pass_cnt++;
    total_cnt++; if (faulty !== 3'b000) $display("FAIL tmr_faulty: got %b want 000", faulty); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL tmr_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  // Bundles 3, 5, 6 are pairwise distinct; their bitwise majority is 7.
  task automatic test_uncorrectable();
    set_reps(32'h3, 32'h5, 32'h6, 1'b1, 1'b0);
    instr_in = 32'h1234; in_valid = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL unc_ready0: got %b want 1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL unc_valid1: got %b want 0", out_valid); else pass_cnt++;
    instr_in = 32'h9999;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL unc_ready1: got %b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (dec_instr_out !== 32'h1234) $display("FAIL unc_held: got %h want 00001234", dec_instr_out); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL unc_valid2: got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL unc_ready2: got %b want 0", in_ready); else pass_cnt++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL unc_valid3: got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (instr_out !== 32'h7) $display("FAIL unc_instr: got %h want 00000007", instr_out); else pass_cnt++;
    total_cnt++; if ({illegal, is_comp, uncorr} !== 3'b111) $display("FAIL unc_flags: got %b want 111", {illegal, is_comp, uncorr}); else pass_cnt++;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL unc_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_reps(32'hAAAA0001, 32'hAAAA0001, 32'hAAAA0001, 1'b0, 1'b0);
    instr_in = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (instr_out !== 32'hAAAA0001) $display("FAIL bp_first: got %h want AAAA0001", instr_out); else pass_cnt++;
    instr_in = 32'h2;
    set_reps(32'hBBBB0002, 32'hBBBB0002, 32'hBBBB0002, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); else pass_cnt++;
      total_cnt++; if ({out_valid, instr_out} !== {1'b1, 32'hAAAA0001}) $display("FAIL bp_hold[%0d]: got %b/%h want 1/AAAA0001", i, out_valid, instr_out); else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if ({out_valid, instr_out} !== {1'b1, 32'hBBBB0002}) $display("FAIL bp_next: got %b/%h want 1/BBBB0002", out_valid, instr_out); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_fault_marking();
    set_reps(32'h13, 32'h12, 32'h13, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      instr_in = 32'h10 + i; in_valid = 1'b1;
      @(posedge clk); #1;
      total_cnt++; if ({out_valid, instr_out, uncorr} !== {1'b1, 32'h13, 1'b0}) $display("FAIL fm_out[%0d]: got %b/%h/%b want 1/00000013/0", i, out_valid, instr_out, uncorr); else pass_cnt++;
      if (i == 6) begin
        total_cnt++; if (faulty !== 3'b000) $display("FAIL fm_early: got %b want 000", faulty); else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (faulty !== 3'b010) $display("FAIL fm_faulty: got %b want 010", faulty); else pass_cnt++;
    total_cnt++; if (mode !== 2'd1) $display("FAIL fm_mode: got %0d want 1", mode); else pass_cnt++;
  endtask

  task automatic test_dmr_retry();
    set_reps(32'h533, 32'hFFFFFFFF, 32'h532, 1'b0, 1'b0);
    instr_in = 32'h77; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if ({out_valid, in_ready} !== 2'b00) $display("FAIL dmr_retry: got %b want 00", {out_valid, in_ready}); else pass_cnt++;
    dec_instr[2] = 32'h533;
    @(posedge clk); #1;
    total_cnt++; if ({out_valid, instr_out} !== {1'b1, 32'h533}) $display("FAIL dmr_out: got %b/%h want 1/00000533", out_valid, instr_out); else pass_cnt++;
    total_cnt++; if ({illegal, uncorr} !== 2'b00) $display("FAIL dmr_flags: got %b want 00", {illegal, uncorr}); else pass_cnt++;
    total_cnt++; if (faulty !== 3'b010) $display("FAIL dmr_faulty: got %b want 010", faulty); else pass_cnt++;
  endtask

  // Replicas 1 and 2 disagree with the majority (7) on every evaluation, so
  // both counters reach 8 together on the third word's first re-evaluation.
  task automatic test_clear_simplex();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    total_cnt++; if ({faulty, mode} !== 5'b000_00) $display("FAIL cs_clear_dmr: got %b/%0d want 000/0", faulty, mode); else pass_cnt++;
    set_reps(32'h7, 32'h3, 32'h5, 1'b0, 1'b0);
    for (int w = 0; w < 3; w++) begin
      instr_in = 32'h40 + w; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int n = 0; n < 8; n++) begin
        if (out_valid) break;
        @(posedge clk); #1;
      end
      total_cnt++; if ({out_valid, instr_out, uncorr} !== {1'b1, 32'h7, 1'b1}) $display("FAIL cs_word[%0d]: got %b/%h/%b want 1/00000007/1", w, out_valid, instr_out, uncorr); else pass_cnt++;
    end
    total_cnt++; if ({faulty, mode} !== 5'b110_10) $display("FAIL cs_simplex: got %b/%0d want 110/2", faulty, mode); else pass_cnt++;
    set_reps(32'h100, 32'h200, 32'h300, 1'b0, 1'b0);
    instr_in = 32'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if ({out_valid, instr_out, uncorr} !== {1'b1, 32'h100, 1'b0}) $display("FAIL cs_pass: got %b/%h/%b want 1/00000100/0", out_valid, instr_out, uncorr); else pass_cnt++;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    total_cnt++; if ({faulty, mode} !== 5'b000_00) $display("FAIL cs_clear: got %b/%0d want 000/0", faulty, mode); else pass_cnt++;
  endtask

  task automatic test_rst_retry();
    set_reps(32'h3, 32'h5, 32'h6, 1'b1, 1'b1);
    instr_in = 32'h66; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total_cnt++; if ({out_valid, in_ready} !== 2'b00) $display("FAIL rr_retry: got %b want 00", {out_valid, in_ready}); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total_cnt++; if ({out_valid, instr_out} !== 33'h0) $display("FAIL rr_out: got %b/%h want 0/00000000", out_valid, instr_out); else pass_cnt++;
    total_cnt++; if ({illegal, is_comp, uncorr, faulty, mode} !== 8'h00) $display("FAIL rr_flags: got %b want 00000000", {illegal, is_comp, uncorr, faulty, mode}); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rr_ready: got %b want 1", in_ready); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rr_quiet[%0d]: got %b want 0", i, out_valid); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_tmr_correct();
    test_uncorrectable();
    test_backpressure();
    test_fault_marking();
    test_dmr_retry();
    test_clear_simplex();
    test_rst_retry();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule
